// File: rtl/dram_arbiter_4.sv
// Single-transaction DRAM arbiter: four round-robin cores plus a priority external port.
// Optional per-core grant counters when ARB_STATS_EN is defined.
module dram_arbiter_4 #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [3:0]            core_req,
   input  logic [3:0]            core_we,
   input  logic [4*ADDR_W-1:0]   core_addr,
   input  logic [4*DATA_W-1:0]   core_wdata,
   output logic [3:0]            core_ack,
   output logic [DATA_W-1:0]     core_rdata,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_W-1:0]     ext_addr,
   input  logic [DATA_W-1:0]     ext_wdata,
   output logic                  ext_ack,
`ifdef ARB_STATS_EN
   input  logic                  stat_clr,
   output logic [4*16-1:0]       stat_grants,
`endif
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic [2:0]            grant_id
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

   state_e              state_q, state_d;
   logic [2:0]          owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [ADDR_W-1:0]   caddr  [4];
   logic [DATA_W-1:0]   cwdata [4];
   logic                core_hit;
   logic [1:0]          core_pick;
   logic [1:0]          idx;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         caddr[i]  = core_addr[i*ADDR_W +: ADDR_W];
         cwdata[i] = core_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin scan starts just after the last core granted; wraps back to it last.
   always_comb begin
      core_hit  = 1'b0;
      core_pick = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!core_hit && core_req[idx]) begin
            core_hit  = 1'b1;
            core_pick = idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (ext_req) begin
               owner_d = 3'd4;
               we_d    = ext_we;
               addr_d  = ext_addr;
               wdata_d = ext_wdata;
               state_d = S_ISSUE;
            end else if (core_hit) begin
               owner_d = {1'b0, core_pick};
               we_d    = core_we[core_pick];
               addr_d  = caddr[core_pick];
               wdata_d = cwdata[core_pick];
               last_d  = core_pick;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_ACK;
            end else begin
               cnt_d   = CNT_W'(RD_LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               rdata_d = mem_rdata;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_en     = (state_q == S_ISSUE);
      mem_we     = (state_q == S_ISSUE) && we_q;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      core_rdata = rdata_q;
      core_ack   = '0;
      if ((state_q == S_ACK) && !owner_q[2]) begin
         core_ack[owner_q[1:0]] = 1'b1;
      end
      ext_ack  = (state_q == S_ACK) && owner_q[2];
      busy     = (state_q != S_IDLE);
      grant_id = (state_q == S_IDLE) ? 3'd7 : owner_q;
   end

`ifdef ARB_STATS_EN
   logic [15:0] grants_q [4];
   logic        core_issue;

   assign core_issue = (state_q == S_IDLE) && !ext_req && core_hit;

   // Clear takes precedence over a same-cycle grant.
   always_ff @(posedge clock) begin
      if (!reset_n || stat_clr) begin
         for (int unsigned i = 0; i < 4; i++) grants_q[i] <= '0;
      end else if (core_issue && (grants_q[core_pick] != '1)) begin
         grants_q[core_pick] <= grants_q[core_pick] + 16'd1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) stat_grants[i*16 +: 16] = grants_q[i];
   end
`endif

endmodule
